// File: rtl/agc_seq_pkg.sv
// Shared constants, opcode/QC encodings and state type for the instruction-path sequencer.
package agc_seq_pkg;

  localparam int unsigned NUM_TP   = 12;
  localparam int unsigned MAX_MCT  = 6;
  localparam int unsigned MCT_W    = $clog2(MAX_MCT + 1);
  localparam int unsigned OP_W     = 3;
  localparam int unsigned QC_W     = 2;
  localparam int unsigned ADDR_W   = 12;

  localparam int unsigned TP4_IDX  = 3;
  localparam int unsigned TP6_IDX  = 5;
  localparam int unsigned TP12_IDX = NUM_TP - 1;

  localparam logic [ADDR_W-1:0] EXTEND_ADDR = 12'o0006;

  localparam logic [OP_W-1:0] OP_TC        = 3'd0;
  localparam logic [OP_W-1:0] OP_CCS_TCF   = 3'd1;
  localparam logic [OP_W-1:0] OP_DAS       = 3'd2;
  localparam logic [OP_W-1:0] OP_CA        = 3'd3;
  localparam logic [OP_W-1:0] OP_CS        = 3'd4;
  localparam logic [OP_W-1:0] OP_INDEX_GRP = 3'd5;
  localparam logic [OP_W-1:0] OP_AD        = 3'd6;
  localparam logic [OP_W-1:0] OP_MASK      = 3'd7;

  localparam logic [QC_W-1:0] QC0 = 2'd0;
  localparam logic [QC_W-1:0] QC1 = 2'd1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_e;

endpackage

// File: rtl/mct_decoder.sv
// Combinational MCT-count decoder: how many memory cycles an instruction takes,
// and whether it is the EXTEND prefix.
module mct_decoder
  import agc_seq_pkg::*;
(
  input  logic [OP_W-1:0]   opcode,
  input  logic [QC_W-1:0]   qc,
  input  logic [ADDR_W-1:0] addr12,
  input  logic              extend,
  output logic [MCT_W-1:0]  mct_total,
  output logic              is_extend
);

  always_comb begin
    mct_total = MCT_W'(2);
    is_extend = 1'b0;
    if (extend) begin
      // Extracode set; an extended op0 is an I/O channel op, never a second EXTEND.
      case (opcode)
        OP_CCS_TCF:   if (qc == QC0) mct_total = MCT_W'(6);
        OP_MASK:      mct_total = MCT_W'(3);
        OP_TC,
        OP_DAS,
        OP_CA,
        OP_CS,
        OP_INDEX_GRP,
        OP_AD:        mct_total = MCT_W'(2);
      endcase
    end else begin
      case (opcode)
        OP_TC: begin
          mct_total = MCT_W'(1);
          is_extend = (addr12 == EXTEND_ADDR);
        end
        OP_CCS_TCF:   mct_total = (qc == QC0) ? MCT_W'(2) : MCT_W'(1);
        OP_DAS:       mct_total = (qc == QC0) ? MCT_W'(3) : MCT_W'(2);
        OP_INDEX_GRP: mct_total = (qc == QC1) ? MCT_W'(3) : MCT_W'(2);
        OP_CA,
        OP_CS,
        OP_AD,
        OP_MASK:      mct_total = MCT_W'(2);
      endcase
    end
  end

endmodule

// File: rtl/mct_sequencer.sv
// Master timing sequencer: TP1..TP12 one-hot ring, per-instruction MCT counter,
// fetch strobe and EXTEND tracking.
module mct_sequencer
  import agc_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              hold,
  input  logic [OP_W-1:0]   opcode,
  input  logic [QC_W-1:0]   qc,
  input  logic [ADDR_W-1:0] addr12,
  output logic [NUM_TP-1:0] tp,
  output logic              tp4,
  output logic [MCT_W-1:0]  mct_index,
  output logic              extend,
  output logic              instr_done,
  output logic              z_inc,
  output logic              busy
);

  seq_state_e        r_state;
  logic [NUM_TP-1:0] r_tp;
  logic [MCT_W-1:0]  r_mct_index;
  logic [MCT_W-1:0]  r_mct_total;
  logic              r_extend;
  logic              r_is_ext;

  logic [MCT_W-1:0]  w_dec_total;
  logic              w_dec_is_ext;
  logic              w_running;
  logic              w_first_mct;
  logic              w_last_mct;
  logic              w_capture;
  logic              w_end_instr;

  mct_decoder u_decoder (
    .opcode    (opcode),
    .qc        (qc),
    .addr12    (addr12),
    .extend    (r_extend),
    .mct_total (w_dec_total),
    .is_extend (w_dec_is_ext)
  );

  assign w_running   = (r_state == ST_RUN);
  assign w_first_mct = (r_mct_index == '0);
  assign w_last_mct  = (r_mct_index == (r_mct_total - MCT_W'(1)));
  assign w_capture   = w_running && r_tp[TP6_IDX] && w_first_mct && !hold;
  assign w_end_instr = w_running && r_tp[TP12_IDX] && w_last_mct && !hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_tp        <= '0;
      r_mct_index <= '0;
      r_mct_total <= MCT_W'(1);
      r_extend    <= 1'b0;
      r_is_ext    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tp <= '0;
          if (run) begin
            r_state     <= ST_RUN;
            r_tp        <= NUM_TP'(1);
            r_mct_index <= '0;
          end
        end
        ST_RUN: begin
          if (!hold) begin
            r_tp <= {r_tp[NUM_TP-2:0], r_tp[NUM_TP-1]};
            if (w_capture) begin
              r_mct_total <= w_dec_total;
              r_is_ext    <= w_dec_is_ext;
            end
            if (r_tp[TP12_IDX]) begin
              if (w_last_mct) begin
                r_mct_index <= '0;
                r_mct_total <= MCT_W'(1);
                r_is_ext    <= 1'b0;
                if (r_extend)      r_extend <= 1'b0;
                else if (r_is_ext) r_extend <= 1'b1;
                // Without run the ring parks; extend survives into the next start.
                if (!run) begin
                  r_state <= ST_IDLE;
                  r_tp    <= '0;
                end
              end else begin
                r_mct_index <= r_mct_index + MCT_W'(1);
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign tp         = r_tp;
  assign mct_index  = r_mct_index;
  assign extend     = r_extend;
  assign busy       = w_running;
  assign tp4        = r_tp[TP4_IDX] && w_first_mct && !hold;
  assign instr_done = w_end_instr;
  assign z_inc      = w_end_instr;

endmodule

// File: doc/mct_sequencer.md
Name: mct_sequencer

Overview:
- Master timing sequencer for the instruction path.
- Generates the twelve one-hot timing pulses TP1..TP12 that make up one memory cycle time (MCT).
- Drives the tp4 fetch strobe into the instruction fetch unit.
- Counts the MCTs each instruction needs, using the decoded opcode/QC/address fed back from fetch, and tracks the EXTEND prefix.
- Sits between the top-level run control and the fetch/execute datapath.

Parameters:
- NUM_TP, 12, timing pulses per MCT.
- EXTEND_ADDR, 12'o0006, Addr12 value that, with OpCode 0, encodes EXTEND.
- MAX_MCT, 6, largest MCT count of any instruction; sizes mct_index.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  level; 1 = execute instructions continuously.
- hold  in  1  level; 1 = freeze the sequence (memory busy).
- opcode  in  3  OpCode from fetch unit.
- qc  in  2  QC from fetch unit.
- addr12  in  12  Addr12 from fetch unit.
- tp  out  12  one-hot timing pulse; bit 0 = TP1.
- tp4  out  1  fetch strobe to fetch unit.
- mct_index  out  3  current MCT within the instruction, 0-based.
- extend  out  1  extracode mode active for the current instruction.
- instr_done  out  1  single-cycle pulse on the last cycle of an instruction.
- z_inc  out  1  single-cycle program-counter increment pulse.
- busy  out  1  sequencer is not idle.

Behaviour:
- Reset (async, immediate, also mid-instruction):
  - state=IDLE.
  - tp=0, mct_index=0, extend=0, tp4=0, instr_done=0, z_inc=0, busy=0.
  - mct_total=1.
- States: IDLE, RUN.
- IDLE:
  - tp=0.
  - run=1 at a clk edge -> RUN with tp=TP1, mct_index=0.
- RUN:
  - Each clk edge with hold=0: tp rotates one position, TP12 -> TP1.
  - hold=1: tp, mct_index, decode latches and extend all keep their value.
- tp4 = tp[TP4] & (mct_index==0) & !hold.
  - Fires in the first MCT only.
  - The fetch unit latches instr while it is high.
- Decode latch:
  - Captures opcode/qc/addr12 on the edge leaving TP6 of MCT 0, with hold=0.
  - Computes mct_total at that point.
  - Until then mct_total=1, and end-of-instruction is not evaluated before TP12.
- MCT table, basic (extend=0):
  - op0: 1 (TC). The same op0 encoding with addr12==EXTEND_ADDR is EXTEND: 1 MCT.
  - op1: qc0 (CCS) 2, else (TCF) 1.
  - op2: qc0 (DAS) 3, else 2.
  - op3: 2. op4: 2.
  - op5: qc1 (DXCH) 3, else 2.
  - op6: 2. op7: 2.
- MCT table, extracode (extend=1):
  - op1 qc0 (DV): 6.
  - op7 (MP): 3.
  - op0 (I/O channel): 2.
  - all others: 2.
- End of MCT, taken on the edge leaving TP12 with hold=0:
  - mct_index==mct_total-1: end of instruction; mct_index<=0, mct_total<=1.
  - otherwise: mct_index increments.
- instr_done and z_inc are high only in the TP12 cycle of the last MCT, with hold=0.
  - They can never be high for more than one cycle.
- extend flag:
  - Set at instr_done of an EXTEND instruction that executed with extend=0.
  - Cleared at instr_done of any instruction that executed with extend=1.
  - An extended op0 is therefore an I/O instruction, not a second EXTEND.
- run deasserted mid-instruction:
  - The current instruction completes.
  - At its instr_done edge state -> IDLE, tp=0.
  - extend is retained, so EXTEND followed by a pause still extends the next instruction.
- run=1 at instr_done: continue seamlessly into TP1 of the next instruction, with no gap cycle.
- hold asserted during TP12 of the last MCT: instr_done and z_inc are suppressed until the cycle hold drops, then pulse once.
- busy = (state==RUN).

Decomposition:
- Shared package agc_seq_pkg holds:
  - NUM_TP and EXTEND_ADDR.
  - Opcode/QC localparams (OP_TC, OP_CCS_TCF, OP_DAS, OP_CA, OP_CS, OP_INDEX_GRP, OP_AD, OP_MASK).
  - The state encoding.
- One combinational sub-module, mct_decoder: (opcode, qc, addr12, extend) -> mct_total[2:0], is_extend.
  - Reused later by the execute control.
- The one-hot ring and the MCT counter stay in mct_sequencer.

Test Plan:
- Reset/start: rst_n low with run=1, all outputs 0. Release rst_n, then the first edge gives tp=12'b000000000001.
  - tp4 is high exactly in cycle 4.
  - A TC instruction (op0, addr12=12'o0100) gives instr_done and z_inc in cycle 12 only; the next cycle is TP1 with mct_index=0.
- Multi-MCT: feed op2 qc0 (DAS) -> mct_index steps 0,1,2.
  - instr_done exactly at cycle 36.
  - tp4 does not fire in MCTs 1 and 2.
- Extend: feed op0 addr12=12'o0006, then op1 qc0.
  - extend=1 during the second instruction, which runs 6 MCTs (72 cycles).
  - extend=0 after its instr_done.
- Hold: assert hold at TP7 for 5 cycles -> tp stays at bit 6 for the hold, then resumes.
  - Hold for 3 cycles at TP12 of the last MCT -> instr_done and z_inc fire once, on the first cycle after hold drops.
- Run drop: deassert run at TP3 of MCT 1 of a DAS -> the instruction completes (instr_done at cycle 36), then tp=0 and busy=0.
  - Re-asserting run resumes at TP1, with extend preserved if it was set.
- Async reset mid-DV: pull rst_n low at MCT 3 TP9, without waiting for a clock edge -> all outputs 0 immediately, extend=0.
